// File: rtl/asic_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// instruction field positions and register-file geometry.
package asic_seq_pkg;

  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_CLR  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // instr = {op[15:12], r[11:8], imm[7:0]}
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int R_MSB   = 11;
  localparam int R_LSB   = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam int IDX_W  = 4;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_OUT,
    ST_HALT
  } state_e;

endpackage

// File: rtl/asic_seq_ctrl_if.sv
// ROM read port and downstream command channel of the sequencer.
//   master: sequencer side (drives rom_ena/rom_addr and cmd_valid/chan/data)
//   slave : environment side (ROM + downstream consumer)
interface asic_seq_ctrl_if #(
  parameter int D_WIDTH    = 16,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  rom_ena;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [D_WIDTH-1:0]    rom_dout;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_chan;
  logic [7:0]            cmd_data;

  modport master (
    output rom_ena, rom_addr, cmd_valid, cmd_chan, cmd_data,
    input  rom_dout, cmd_ready
  );

  modport slave (
    input  rom_ena, rom_addr, cmd_valid, cmd_chan, cmd_data,
    output rom_dout, cmd_ready
  );
endinterface

// File: rtl/asic_seq_regfile.sv
// NUM_REGS x 8 register file: one synchronous write port, one
// combinational read port, synchronous active-high clear.
// Indices at or above NUM_REGS write nothing and read 0x00.
module asic_seq_regfile
  import asic_seq_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d  = regs_q;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we && wr_idx == IDX_W'(i)) regs_d[i] = wr_data;
      if (rd_idx == IDX_W'(i))       rd_data   = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: rtl/asic_seq_ctrl.sv
// Program sequencer: fetches 16-bit words from ROM address 0, executes
// LDI/OUT/CLR/HALT (others are NOPs) and emits register values on a
// valid/ready command channel.
//   clka/rsta : clock, synchronous active-high reset
//   start     : 1-cycle pulse, (re)starts at address 0 from IDLE or HALT
//   busy/done/err : status (done = HALT instr, err = ran off the ROM end)
//   bus       : ROM read port + command channel (master side)
module asic_seq_ctrl
  import asic_seq_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int NUM_REGS   = 16
) (
  input  logic            clka,
  input  logic            rsta,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  asic_seq_ctrl_if.master bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      chan_q, chan_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic [D_WIDTH-1:0]    instr;
  logic [3:0]            op;
  logic [IDX_W-1:0]      r;
  logic [DATA_W-1:0]     imm;
  logic                  rf_we;
  logic [DATA_W-1:0]     rf_wdata, rf_rdata;
  logic                  adv;
  logic                  last;

  assign instr = bus.rom_dout;
  assign op    = instr[OP_MSB:OP_LSB];
  assign r     = instr[R_MSB:R_LSB];
  assign imm   = instr[IMM_MSB:IMM_LSB];
  assign last  = (pc_q == ADDR_WIDTH'(DEPTH - 1));

  asic_seq_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clka),
    .rst     (rsta),
    .we      (rf_we),
    .wr_idx  (r),
    .wr_data (rf_wdata),
    .rd_idx  (r),
    .rd_data (rf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    done_d   = done_q;
    err_d    = err_q;
    chan_d   = chan_q;
    data_d   = data_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    adv      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = imm;
            adv      = 1'b1;
          end
          OP_CLR: begin
            rf_we = 1'b1;
            adv   = 1'b1;
          end
          OP_OUT: begin
            chan_d  = r;
            data_d  = rf_rdata;
            state_d = ST_OUT;
          end
          OP_HALT: begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end
          default: adv = 1'b1;
        endcase
      end
      ST_OUT: if (bus.cmd_ready) adv = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // Completing a non-HALT instruction at the last ROM word stops with an
    // error instead of wrapping; pc is left pointing at that word.
    if (adv) begin
      if (last) begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end else begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
    end
  end

  assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign done          = done_q;
  assign err           = err_q;
  assign bus.rom_ena   = (state_q == ST_FETCH);
  assign bus.rom_addr  = pc_q;
  assign bus.cmd_valid = (state_q == ST_OUT);
  assign bus.cmd_chan  = chan_q;
  assign bus.cmd_data  = data_q;
endmodule
